sdram_controller: RTL

Initiator-side controller for the SDRAM block: accepts single-word read/write requests from the CPU memory stage and drives the SDRAM command/address/data pins through the full init, activate, read/write, precharge and refresh sequence. It owns all SDRAM timing, one access at a time with a closed-page policy. Read data returns on a one-cycle response strobe.

---
 rtl/sdram_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sdram_controller.sv
// SDRAM initiator: init, refresh and one closed-page single-word access at a time; read response after T_RCD+CAS_LATENCY+2 cycles.
// req_ready is high only in IDLE with no refresh pending; a held request is taken on the first ready cycle.
module sdram_controller #(
  parameter int INIT_CYCLES      = 100,
  parameter int T_RCD            = 2,
  parameter int CAS_LATENCY      = 2,
  parameter int T_RP             = 2,
  parameter int T_RFC            = 7,
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        init_done,
  output logic        clock_enable,
  output logic [2:0]  sdram_cmd,
  output logic        wr_en,
  output logic [12:0] sdram_address,
  output logic [1:0]  bank_address,
  inout  wire  [31:0] rw_data
);

  typedef enum logic [3:0] {
    INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, IDLE, ACTIVATE, RCD_WAIT,
    ACCESS, CAS_WAIT, PRECHARGE, RP_WAIT, REFRESH, RFC_WAIT
  } state_t;

  typedef struct packed {
    logic        write;
    logic [12:0] row;
    logic [1:0]  bank;
    logic [8:0]  col;
    logic [31:0] wdata;
  } req_t;

  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_ACTIVE    = 3'd1;
  localparam logic [2:0] CMD_READ      = 3'd2;
  localparam logic [2:0] CMD_WRITE     = 3'd3;
  localparam logic [2:0] CMD_PRECHARGE = 3'd4;
  localparam logic [2:0] CMD_REFRESH   = 3'd5;

  localparam logic [12:0] PRE_ALL_ADDR = 13'h0400;

  // Wait-state exit values; the command cycle itself is the first cycle of each interval.
  localparam logic [31:0] INIT_LAST     = 32'(INIT_CYCLES);
  localparam logic [31:0] INIT_RP_LAST  = 32'(T_RP - 1);
  localparam logic [31:0] INIT_RFC_LAST = 32'(T_RFC - 1);
  localparam logic [31:0] RCD_LAST      = 32'(T_RCD - 2);
  localparam logic [31:0] CAS_LAST      = 32'(CAS_LATENCY - 1);
  localparam logic [31:0] RP_LAST       = 32'(T_RP - 2);
  localparam logic [31:0] RFC_LAST      = 32'(T_RFC - 2);
  localparam logic [31:0] REF_LAST      = 32'(REFRESH_INTERVAL - 1);

  state_t      state_q, state_d, after_rp;
  logic [31:0] cnt_q;
  logic [31:0] ref_cnt_q;
  logic        refresh_pending;
  req_t        req_q;
  logic        accept;
  logic        read_capture;
  logic        refresh_done;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{req_address[31:26], req_address[1:0]};

  assign req_ready    = (state_q == IDLE) && !refresh_pending;
  assign accept       = (state_q == IDLE) && (state_d == ACTIVATE);
  assign read_capture = (state_q == CAS_WAIT) && (state_d == PRECHARGE);
  assign refresh_done = ((state_q == REFRESH) || (state_q == RFC_WAIT)) && (state_d == IDLE);

  // A refresh that fell due during an access goes out in place of the first IDLE cycle.
  assign after_rp = refresh_pending ? REFRESH : IDLE;

  assign rw_data = wr_en ? req_q.wdata : {32{1'bz}};

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_WAIT: if (cnt_q == INIT_LAST)     state_d = INIT_PRE;
      INIT_PRE:  if (cnt_q == INIT_RP_LAST)  state_d = INIT_REF1;
      INIT_REF1: if (cnt_q == INIT_RFC_LAST) state_d = INIT_REF2;
      INIT_REF2: if (cnt_q == INIT_RFC_LAST) state_d = IDLE;
      IDLE: begin
        if (refresh_pending)  state_d = REFRESH;
        else if (req_valid)   state_d = ACTIVATE;
      end
      ACTIVATE:  state_d = (T_RCD > 1) ? RCD_WAIT : ACCESS;
      RCD_WAIT:  if (cnt_q == RCD_LAST) state_d = ACCESS;
      ACCESS:    state_d = req_q.write ? PRECHARGE : CAS_WAIT;
      CAS_WAIT:  if (cnt_q == CAS_LAST) state_d = PRECHARGE;
      PRECHARGE: state_d = (T_RP > 1) ? RP_WAIT : after_rp;
      RP_WAIT:   if (cnt_q == RP_LAST) state_d = after_rp;
      REFRESH:   state_d = (T_RFC > 1) ? RFC_WAIT : IDLE;
      RFC_WAIT:  if (cnt_q == RFC_LAST) state_d = IDLE;
      default:   state_d = INIT_WAIT;
    endcase
  end

  always_comb begin
    sdram_cmd     = CMD_NOP;
    sdram_address = '0;
    bank_address  = '0;
    wr_en         = 1'b0;
    case (state_q)
      INIT_PRE: begin
        if (cnt_q == '0) begin
          sdram_cmd     = CMD_PRECHARGE;
          sdram_address = PRE_ALL_ADDR;
        end
      end
      INIT_REF1, INIT_REF2: if (cnt_q == '0) sdram_cmd = CMD_REFRESH;
      ACTIVATE: begin
        sdram_cmd     = CMD_ACTIVE;
        sdram_address = req_q.row;
        bank_address  = req_q.bank;
      end
      ACCESS: begin
        sdram_cmd     = req_q.write ? CMD_WRITE : CMD_READ;
        sdram_address = {4'b0, req_q.col};
        bank_address  = req_q.bank;
        wr_en         = req_q.write;
      end
      PRECHARGE: begin
        sdram_cmd     = CMD_PRECHARGE;
        sdram_address = PRE_ALL_ADDR;
      end
      REFRESH:  sdram_cmd = CMD_REFRESH;
      default:  sdram_cmd = CMD_NOP;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= INIT_WAIT;
      cnt_q           <= '0;
      clock_enable    <= 1'b0;
      init_done       <= 1'b0;
      ref_cnt_q       <= '0;
      refresh_pending <= 1'b0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      req_q           <= '0;
    end else begin
      clock_enable <= 1'b1;
      state_q      <= state_d;
      cnt_q        <= (state_d != state_q) ? '0 : cnt_q + 32'd1;
      resp_valid   <= read_capture;

      if (state_q == INIT_REF2 && state_d == IDLE) init_done <= 1'b1;

      // Expiry is checked after the clear so a coincident expiry is not lost.
      if (refresh_done) refresh_pending <= 1'b0;
      if (init_done) begin
        if (ref_cnt_q == REF_LAST) begin
          ref_cnt_q       <= '0;
          refresh_pending <= 1'b1;
        end else begin
          ref_cnt_q <= ref_cnt_q + 32'd1;
        end
      end

      if (accept) begin
        req_q <= '{write: req_write, row: req_address[25:13], bank: req_address[12:11],
                   col: req_address[10:2], wdata: req_wdata};
      end
      if (read_capture) resp_rdata <= rw_data;
    end
  end

endmodule
